// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for the core fetch port, filled at runtime
// through a byte-serial boot-load port. Fetch returns NOP until a load session
// has finished and the machine is in RUN.
// Optional feature: define INST_ROM_CHECKSUM_EN to build the running word
// checksum on checksum_o; otherwise checksum_o is tied to zero.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    output logic              misalign_o,
    input  logic              ld_en_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   ld_words_o,
    output logic              ld_full_o,
    output logic              ld_err_o,
    output logic              run_o,
    output logic [31:0]       checksum_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state, state_nx;
    logic              load_entry, load_exit;
    logic              accept, word_we;
    logic [ADDR_W:0]   wptr;
    logic [1:0]        bcnt;
    logic [23:0]       sh;
    logic [31:0]       word;
    logic [31:0]       addr_hi;
    logic              fetch_ok;
    logic [31:0]       mem [2**ADDR_W];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic, session entry/exit strobes and load-port handshake
    always_comb begin
        state_nx   = state;
        load_entry = 1'b0;
        load_exit  = 1'b0;
        ld_ready_o = 1'b0;
        run_o      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_en_i) begin
                    state_nx   = S_LOAD;
                    load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                ld_ready_o = ld_en_i & ~ld_full_o;
                if (!ld_en_i) begin
                    state_nx  = S_RUN;
                    load_exit = 1'b1;
                end
            end
            S_RUN: begin
                run_o = 1'b1;
                if (ld_en_i) begin
                    state_nx   = S_LOAD;
                    load_entry = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept     = ld_valid_i & ld_ready_o;
    assign word_we    = accept & (bcnt == 2'd3);
    assign word       = {sh, ld_byte_i};
    assign ld_full_o  = wptr[ADDR_W];
    assign ld_words_o = wptr;

    // Byte assembly, word pointer and sticky partial-word error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            bcnt     <= '0;
            sh       <= '0;
            ld_err_o <= 1'b0;
        end else if (load_entry) begin
            wptr     <= '0;
            bcnt     <= '0;
            ld_err_o <= 1'b0;
        end else if (load_exit) begin
            bcnt <= '0;
            if (bcnt != 2'd0) ld_err_o <= 1'b1;
        end else if (accept) begin
            sh   <= {sh[15:0], ld_byte_i};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) wptr <= wptr + 1'b1;
        end
    end

    // Word array write; contents survive reset by design
    always_ff @(posedge clk) begin
        if (word_we) mem[wptr[ADDR_W-1:0]] <= word;
    end

`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] csum;

    // Running sum of words written in the current session
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            csum <= '0;
        else if (load_entry) csum <= '0;
        else if (word_we)    csum <= csum + word;
    end

    assign checksum_o = csum;
`else
    assign checksum_o = '0;
`endif

    // Fetch path: stored word only in RUN with an in-range address, else NOP
    always_comb begin
        addr_hi    = addr_i >> (ADDR_W + 2);
        fetch_ok   = (state == S_RUN) && ce_i && (addr_hi == '0);
        inst_o     = fetch_ok ? mem[addr_i[ADDR_W+1:2]] : '0;
        misalign_o = ce_i & (|addr_i[1:0]);
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader (small ADDR_W so the full boundary
// is reachable). Loaded words are pushed to a scoreboard and popped on fetch.
module tb_inst_rom_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic [31:0]   addr_i;
    logic [31:0]   inst_o;
    logic          misalign_o;
    logic          ld_en_i;
    logic          ld_valid_i;
    logic [7:0]    ld_byte_i;
    logic          ld_ready_o;
    logic [AW:0]   ld_words_o;
    logic          ld_full_o;
    logic          ld_err_o;
    logic          run_o;
    logic [31:0]   checksum_o;

    inst_rom_loader #(.ADDR_W(AW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .misalign_o (misalign_o),
        .ld_en_i    (ld_en_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_ready_o (ld_ready_o),
        .ld_words_o (ld_words_o),
        .ld_full_o  (ld_full_o),
        .ld_err_o   (ld_err_o),
        .run_o      (run_o),
        .checksum_o (checksum_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] m_mem [DEPTH];
    logic [23:0] m_sh;
    int          m_bcnt;
    int          m_words;
    logic [31:0] m_csum;
    logic        m_err;
    logic        m_load;
    logic        m_run;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_csum();
`ifdef INST_ROM_CHECKSUM_EN
        return m_csum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_load  = 1'b0;
        m_run   = 1'b0;
        m_words = 0;
        m_bcnt  = 0;
        m_sh    = '0;
        m_csum  = '0;
        m_err   = 1'b0;
    endtask

    task automatic start_load();
        ld_en_i = 1'b1;
        step();
        m_load  = 1'b1;
        m_run   = 1'b0;
        m_words = 0;
        m_bcnt  = 0;
        m_csum  = '0;
        m_err   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic        acc;
        logic [31:0] w;
        acc        = m_load && ld_en_i && (m_words < DEPTH);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        step();
        ld_valid_i = 1'b0;
        if (acc) begin
            w    = {m_sh, b};
            m_sh = {m_sh[15:0], b};
            m_bcnt++;
            if (m_bcnt == 4) begin
                m_mem[m_words] = w;
                sb.push_back('{addr: 32'(m_words * 4), data: w});
                m_csum  = m_csum + w;
                m_words++;
                m_bcnt  = 0;
            end
        end
    endtask

    task automatic end_load(input logic offer, input logic [7:0] b);
        ld_en_i    = 1'b0;
        ld_valid_i = offer;
        ld_byte_i  = b;
        step();
        ld_valid_i = 1'b0;
        if (m_bcnt != 0) m_err = 1'b1;
        m_bcnt = 0;
        m_load = 1'b0;
        m_run  = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_words"}, 32'(ld_words_o), 32'(m_words));
        check_val({tag, "_full"},  32'(ld_full_o),  32'(m_words == DEPTH));
        check_val({tag, "_err"},   32'(ld_err_o),   32'(m_err));
        check_val({tag, "_run"},   32'(run_o),      32'(m_run));
        check_val({tag, "_csum"},  checksum_o,      exp_csum());
    endtask

    task automatic drain_fetch(input string tag);
        exp_t e;
        ce_i = 1'b1;
        while (sb.size() > 0) begin
            e      = sb.pop_front();
            addr_i = e.addr;
            #1;
            check_val(tag, inst_o, e.data);
        end
    endtask

    initial begin
        rst        = 1'b0;
        ce_i       = 1'b1;
        addr_i     = '0;
        ld_en_i    = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = '0;
        model_reset();
        #12;
        check_val("rst_inst",  inst_o, 32'h0);
        check_val("rst_ready", 32'(ld_ready_o), 32'h0);
        check_status("rst");
        step();
        rst = 1'b1;
        step();

        // Two-word load
        start_load();
        check_val("load_ready", 32'(ld_ready_o), 32'h1);
        check_val("load_nop",   inst_o, 32'h0);
        foreach (m_mem[i]) m_mem[i] = 'x;
        send_byte(8'h34); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h21); send_byte(8'h00); send_byte(8'h02);
        end_load(1'b0, 8'h00);
        check_status("two_words");
        check_val("two_words_const", 32'(ld_words_o), 32'd2);
        addr_i = 32'd4; #1;
        check_val("inst_a4_const", inst_o, 32'h34210002);
        addr_i = 32'd0; #1;
        check_val("inst_a0_const", inst_o, 32'h34200001);
`ifdef INST_ROM_CHECKSUM_EN
        check_val("csum_const", checksum_o, 32'h68410003);
`endif
        drain_fetch("fetch_two");

        // Address qualification
        addr_i = 32'd2; #1;
        check_val("misalign_flag", 32'(misalign_o), 32'h1);
        check_val("misalign_inst", inst_o, m_mem[0]);
        addr_i = 32'(DEPTH * 4); #1;
        check_val("oob_edge_inst", inst_o, 32'h0);
        addr_i = 32'h00001000; #1;
        check_val("oob_far_inst", inst_o, 32'h0);
        addr_i = 32'd4; ce_i = 1'b0; #1;
        check_val("ce_off_inst",     inst_o, 32'h0);
        check_val("ce_off_misalign", 32'(misalign_o), 32'h0);
        ce_i = 1'b1;

        // Reload from RUN: fetch visible until the entry edge, NOP afterwards
        ld_en_i = 1'b1; #1;
        check_val("run_pre_entry", inst_o, m_mem[1]);
        start_load();
        check_val("run_post_entry", inst_o, 32'h0);
        check_status("reload_entry");

        // Partial word plus a byte offered on the falling ld_en_i edge
        for (int unsigned i = 0; i < 7; i++) send_byte(8'(8'hA0 + i));
        end_load(1'b1, 8'hEE);
        check_status("partial");
        check_val("partial_err_const", 32'(ld_err_o), 32'h1);
        drain_fetch("fetch_partial");
        addr_i = 32'd4; #1;
        check_val("stale_word", inst_o, m_mem[1]);

        // New session clears the error, then overfill
        start_load();
        check_val("err_cleared", 32'(ld_err_o), 32'h0);
        for (int unsigned i = 0; i < 20; i++) begin
            send_byte(8'(i * 17 + 3));
            check_val("fill_full",  32'(ld_full_o),  32'(m_words == DEPTH));
            check_val("fill_ready", 32'(ld_ready_o), 32'(m_words < DEPTH));
        end
        end_load(1'b0, 8'h00);
        check_status("full");
        drain_fetch("fetch_full");

        // Reset in the middle of a word
        start_load();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        ld_en_i    = 1'b0;
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'h44;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_val("midrst_inst",  inst_o, 32'h0);
        check_val("midrst_ready", 32'(ld_ready_o), 32'h0);
        check_status("midrst");
        step();
        ld_valid_i = 1'b0;
        rst = 1'b1;
        step();
        check_val("postrst_run", 32'(run_o), 32'h0);
        start_load();
        end_load(1'b0, 8'h00);
        check_status("empty_load");
        addr_i = 32'd0; #1;
        check_val("midrst_mem0", inst_o, m_mem[0]);
        check_val("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the core's fetch port. It answers `ce_i`/`addr_i` with a 32-bit instruction in the same cycle, so the IF/ID register samples it on the next edge. Its word array is filled at runtime by a byte-serial boot-load port, and a load state machine gates fetch until a load has finished. It sits between the core's `rom_addr_o`/`rom_ce_o`/`rom_data_i` and the board-level loader.

## Interface
- `ADDR_W`, default 10: word-index width; depth is 2^ADDR_W words of 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce_i`  in  1  fetch enable from the core.
- `addr_i`  in  32  fetch byte address, i.e. the PC.
- `inst_o`  out  32  fetched instruction; combinational from `ce_i`, `addr_i` and state.
- `misalign_o`  out  1  combinational: `ce_i` high and `addr_i[1:0]` nonzero.
- `ld_en_i`  in  1  level; high requests and holds a load session.
- `ld_valid_i`  in  1  byte valid.
- `ld_byte_i`  in  8  load byte, big-endian within each word.
- `ld_ready_o`  out  1  combinational: asserted only when the state is LOAD, `ld_en_i` is high and `ld_full_o` is low.
- `ld_words_o`  out  ADDR_W+1  number of words written in the current or last session.
- `ld_full_o`  out  1  `ld_words_o` equals 2^ADDR_W.
- `ld_err_o`  out  1  sticky: the last session ended on a partial word.
- `run_o`  out  1  the state is RUN.
- `checksum_o`  out  32  see Configuration.

## Operation
- States: IDLE (reset state), LOAD, RUN.
- IDLE or RUN → LOAD when `ld_en_i` is 1. On that entry edge:
  - `wptr`, `bcnt` and the checksum clear to 0.
  - `ld_err_o` clears.
- LOAD → RUN when `ld_en_i` is 0.
  - If `bcnt` is nonzero, the partial word is discarded and `ld_err_o` is set.
  - `bcnt` clears.
- A byte is accepted on an edge where `ld_valid_i` and `ld_ready_o` are both 1.
  - Shift register update: `sh = {sh[23:0], ld_byte_i}`; `bcnt` increments modulo 4.
  - On the 4th byte, `mem[wptr]` is written with `{sh[23:0], ld_byte_i}` and `wptr` increments.
  - `ld_words_o` equals `wptr`.
- Full: when `wptr` equals 2^ADDR_W, `ld_ready_o` is 0 and further bytes are ignored. `wptr` does not wrap. The session still ends normally when `ld_en_i` falls.
- Fetch returns the stored word only when all of the following hold; otherwise `inst_o` is 32'h0 (NOP):
  - the state is RUN;
  - `ce_i` is 1;
  - `addr_i[31:ADDR_W+2]` is 0.
- The stored word returned is `mem[addr_i[ADDR_W+1:2]]`.
- `addr_i[1:0]` is ignored for the read and only drives `misalign_o`.
- Words that were not loaded in the current session return stale contents. The memory array is not reset.

## Timing
- Reset values: state IDLE, `ld_ready_o` 0, `ld_words_o` 0, `ld_full_o` 0, `ld_err_o` 0, `run_o` 0, `checksum_o` 0, `inst_o` 0.
- Fetch latency is 0 cycles (combinational). A word written at edge N is readable after edge N, once the state is RUN.
- `ld_en_i` falling and `ld_valid_i` high in the same cycle: `ld_ready_o` is already 0, so the byte is not accepted.
- `ld_en_i` rising in RUN: fetch returns NOP from the next cycle on.
- Reset during LOAD: the machine returns to IDLE immediately. Memory words already written are kept; the partial word is lost. `ld_err_o` is not set, because it resets to 0.
- Back-to-back bytes: one per cycle, which is 4 cycles per word.

## Configuration
- Macro `INST_ROM_CHECKSUM_EN`.
- Defined:
  - `checksum_o` is the modulo-2^32 sum of all words written in the session.
  - It is updated on the same edge as the write and cleared on entry to LOAD.
  - It holds its value in RUN.
- Undefined: `checksum_o` is tied to 32'h0 and the adder is not built.

## Test plan
- Reset, then `ce_i`=1 and `addr_i`=0 → `inst_o`=0, `run_o`=0 and `ld_ready_o`=0.
- Load bytes 34 20 00 01 and 34 21 00 02, then drop `ld_en_i` → `ld_words_o`=2 and `run_o`=1. `addr_i`=4 gives `inst_o`=32'h34210002; `addr_i`=0 gives 32'h34200001. With `INST_ROM_CHECKSUM_EN` defined, `checksum_o`=32'h68410003.
- Load 6 bytes, then drop `ld_en_i` → `ld_words_o`=1 and `ld_err_o`=1. Starting a new load clears `ld_err_o`.
- With ADDR_W=2, stream 20 valid bytes → `ld_full_o`=1 after the 16th byte and `ld_ready_o`=0. Bytes 17-20 are ignored and `mem[0]` is unchanged.
- In RUN, `addr_i`=32'h00001000 (ADDR_W=10) → `inst_o`=0. `addr_i`=2 → `misalign_o`=1 and `inst_o`=`mem[0]`. `ce_i`=0 → `inst_o`=0.
- Assert `rst` low after the 3rd byte of a word → the state goes to IDLE with all outputs at their reset values in the same cycle, and `mem[0]` is not written.
